vram_fetch_unit: RTL

- Parametrised video-RAM fetch sequencer for the CPC/Plus motherboard. It sits between the gate-array RAS/CAS/CPU timing strobes, the CRTC address and the wide video RAM port.
- Splits each WORD_W-bit VRAM word into consecutive byte slots, one per CAS pulse, and presents them to the gate array as an 8-bit pixel byte.
- Supports a run-time-selectable byte delay (0..MAX_SHIFT slots) with display-enable masking for sync-filtered and soft-scroll modes.

---
 rtl/vram_fetch_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/vram_fetch_unit.sv
// Video-RAM fetch sequencer: slices each wide VRAM word into CAS-timed byte slots
// and feeds the gate array through an optional, display-enable-masked byte delay line.
module vram_fetch_unit #(
  parameter int WORD_W    = 16,
  parameter int ADDR_W    = 15,
  parameter int MAX_SHIFT = 1,
  parameter int SH_W      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_n,
  input  logic                 ras_n,
  input  logic                 cas_n,
  input  logic [ADDR_W-1:0]    crtc_addr,
  input  logic [WORD_W-1:0]    vram_din,
  input  logic                 de,
  input  logic                 shift_en,
  input  logic [SH_W-1:0]      shift_amt,
  output logic [ADDR_W-1:0]    vram_addr,
  output logic [7:0]           vram_d,
  output logic [((WORD_W/8) > 1 ? $clog2(WORD_W/8) : 1)-1:0] byte_idx,
  output logic                 slot_stb,
  output logic                 overrun
);

  localparam int BYTES = WORD_W / 8;
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BI_W-1:0] LAST_IDX  = BI_W'(BYTES - 1);
  localparam logic [SH_W-1:0] MAX_SH_C  = SH_W'(MAX_SHIFT);

  logic              cas_n_q_r;
  logic [BI_W-1:0]   byte_idx_r;
  logic [ADDR_W-1:0] vram_addr_r;
  logic [7:0]        vram_d_r;
  logic              slot_stb_r;
  logic              overrun_r;
  logic [7:0]        dl_r [MAX_SHIFT];

  logic              slot_s;
  logic              cas_rise_s;
  logic [SH_W-1:0]   eff_shift_s;
  logic [7:0]        raw_byte_s;
  logic [7:0]        masked_byte_s;
  logic [7:0]        dly_byte_s;
  logic [BI_W-1:0]   byte_idx_nxt_s;
  logic              overrun_nxt_s;
  logic [ADDR_W-1:0] vram_addr_nxt_s;
  logic [7:0]        vram_d_nxt_s;

  // Strobe decode, shift clamp and byte selection
  always_comb begin
    slot_s        = cpu_n & ~ras_n & ~cas_n & cas_n_q_r;
    cas_rise_s    = ~ras_n & cas_n & ~cas_n_q_r;
    eff_shift_s   = (shift_amt > MAX_SH_C) ? MAX_SH_C : shift_amt;
    raw_byte_s    = 8'h00;
    dly_byte_s    = 8'h00;
    // One-hot OR-muxes keep non-power-of-two word widths safe
    for (int i = 0; i < BYTES; i++) begin
      raw_byte_s = raw_byte_s | ((byte_idx_r == BI_W'(i)) ? vram_din[8*i +: 8] : 8'h00);
    end
    for (int k = 0; k < MAX_SHIFT; k++) begin
      dly_byte_s = dly_byte_s | ((eff_shift_s == SH_W'(k + 1)) ? dl_r[k] : 8'h00);
    end
    masked_byte_s = de ? raw_byte_s : 8'h00;
  end

  // Next-state for slot index, overrun flag, address and pixel byte
  always_comb begin
    byte_idx_nxt_s  = byte_idx_r;
    overrun_nxt_s   = overrun_r;
    vram_addr_nxt_s = vram_addr_r;
    vram_d_nxt_s    = vram_d_r;

    // CPU phase resets the index even if CAS rises in the same cycle
    if (!cpu_n) begin
      byte_idx_nxt_s = {BI_W{1'b0}};
    end else if (cas_rise_s) begin
      if (byte_idx_r < LAST_IDX) begin
        byte_idx_nxt_s = byte_idx_r + BI_W'(1);
      end else begin
        byte_idx_nxt_s = LAST_IDX;
        overrun_nxt_s  = 1'b1;
      end
    end else begin
      byte_idx_nxt_s = byte_idx_r;
    end

    if (cpu_n) begin
      vram_addr_nxt_s = crtc_addr;
    end else begin
      vram_addr_nxt_s = vram_addr_r;
    end

    if (slot_s) begin
      if (!shift_en || (eff_shift_s == {SH_W{1'b0}})) begin
        vram_d_nxt_s = raw_byte_s;
      end else begin
        vram_d_nxt_s = dly_byte_s;
      end
    end else begin
      vram_d_nxt_s = vram_d_r;
    end
  end

  // State registers; the delay line survives CPU phases to stagger bytes across words
  always_ff @(posedge clk) begin
    if (reset) begin
      cas_n_q_r   <= 1'b1;
      byte_idx_r  <= {BI_W{1'b0}};
      vram_addr_r <= {ADDR_W{1'b0}};
      vram_d_r    <= 8'h00;
      slot_stb_r  <= 1'b0;
      overrun_r   <= 1'b0;
      for (int k = 0; k < MAX_SHIFT; k++) begin
        dl_r[k] <= 8'h00;
      end
    end else begin
      cas_n_q_r   <= cas_n;
      byte_idx_r  <= byte_idx_nxt_s;
      vram_addr_r <= vram_addr_nxt_s;
      vram_d_r    <= vram_d_nxt_s;
      slot_stb_r  <= slot_s;
      overrun_r   <= overrun_nxt_s;
      if (slot_s) begin
        dl_r[0] <= masked_byte_s;
        for (int k = 1; k < MAX_SHIFT; k++) begin
          dl_r[k] <= dl_r[k-1];
        end
      end
    end
  end

  assign vram_addr = vram_addr_r;
  assign vram_d    = vram_d_r;
  assign byte_idx  = byte_idx_r;
  assign slot_stb  = slot_stb_r;
  assign overrun   = overrun_r;

endmodule
